// File: rtl/packet_injector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | packet_injector                                                            |
// | NoC packet source: buffers whole packets, serialises them into flits and   |
// | follows credit-based flow control. Optional throttle: define               |
// | PACKET_INJECTOR_THROTTLE_EN to insert GAP idle cycles after each packet.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module packet_injector #(
  parameter int CHANNEL_WIDTH = 16,
  parameter int FLITS         = 5,
  parameter int CREDITS       = 2,
  parameter int DEPTH         = 4,
  parameter int GAP           = 0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [FLITS*CHANNEL_WIDTH-1:0]   pkt_in,
  input  logic                             pkt_valid,
  output logic                             pkt_ready,
  input  logic                             credit_in,
  output logic [CHANNEL_WIDTH-1:0]         channel_out,
  output logic [31:0]                      packet_count,
  output logic [$clog2(CREDITS+1)-1:0]     credits,
  output logic                             credit_err
);

  localparam int PKT_W = FLITS * CHANNEL_WIDTH;
  localparam int AW    = $clog2(DEPTH);
  localparam int CRW   = $clog2(CREDITS + 1);
  localparam int IW    = $clog2(FLITS);

  localparam logic [CRW-1:0] CRED_MAX = CRW'(CREDITS);
  localparam logic [IW-1:0]  LAST_IDX = IW'(FLITS - 1);
  localparam logic [AW:0]    FULL_CNT = (AW + 1)'(DEPTH);

  if (FLITS < 2 || FLITS > 16 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
      CREDITS < 1 || GAP < 0) begin : g_param_check
    $error("packet_injector: illegal parameter combination");
  end

`ifdef PACKET_INJECTOR_THROTTLE_EN
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SEND = 2'd1, ST_GAP = 2'd2} state_t;
  logic [GW-1:0] gap_q, gap_d;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SEND = 2'd1} state_t;
`endif

  state_t             state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [PKT_W-1:0]   shift_q, shift_d;
  logic [CHANNEL_WIDTH-1:0] channel_out_q, channel_out_d;
  logic [31:0]        packet_count_q, packet_count_d;
  logic [CRW-1:0]     credits_q, credits_d;
  logic               credit_err_q, credit_err_d;

  logic [PKT_W-1:0]   mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]        count_q, count_d;
  logic [PKT_W-1:0]   head;
  logic               fifo_empty;
  logic               push;
  logic               pop;

  assign pkt_ready  = (count_q != FULL_CNT);
  assign fifo_empty = (count_q == '0);
  assign push       = pkt_valid && pkt_ready;
  assign head       = mem_q[rd_ptr_q];

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    shift_d        = shift_q;
    channel_out_d  = '0;
    packet_count_d = packet_count_q;
    credits_d      = credits_q;
    credit_err_d   = credit_err_q;
    pop            = 1'b0;
`ifdef PACKET_INJECTOR_THROTTLE_EN
    gap_d          = gap_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        // Credits are only consulted here, at packet boundaries.
        if (!fifo_empty && credits_q != '0) begin
          pop           = 1'b1;
          channel_out_d = head[CHANNEL_WIDTH-1:0];
          shift_d       = head >> CHANNEL_WIDTH;
          idx_d         = IW'(1);
          state_d       = ST_SEND;
        end
      end
      ST_SEND: begin
        channel_out_d = shift_q[CHANNEL_WIDTH-1:0];
        shift_d       = shift_q >> CHANNEL_WIDTH;
        idx_d         = idx_q + IW'(1);
        if (idx_q == LAST_IDX) begin
          packet_count_d = packet_count_q + 32'd1;
          idx_d          = '0;
`ifdef PACKET_INJECTOR_THROTTLE_EN
          if (GAP > 0) begin
            state_d = ST_GAP;
            gap_d   = GW'(GAP);
          end else begin
            state_d = ST_IDLE;
          end
`else
          state_d = ST_IDLE;
`endif
        end
      end
`ifdef PACKET_INJECTOR_THROTTLE_EN
      ST_GAP: begin
        // The final gap cycle is spent in IDLE deciding the next launch.
        if (gap_q <= GW'(1)) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    if (pop && !credit_in) begin
      credits_d = credits_q - CRW'(1);
    end else if (!pop && credit_in) begin
      if (credits_q == CRED_MAX) begin
        credit_err_d = 1'b1;
      end else begin
        credits_d = credits_q + CRW'(1);
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= pkt_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      idx_q          <= '0;
      shift_q        <= '0;
      channel_out_q  <= '0;
      packet_count_q <= '0;
      credits_q      <= CRED_MAX;
      credit_err_q   <= 1'b0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
`ifdef PACKET_INJECTOR_THROTTLE_EN
      gap_q          <= '0;
`endif
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      shift_q        <= shift_d;
      channel_out_q  <= channel_out_d;
      packet_count_q <= packet_count_d;
      credits_q      <= credits_d;
      credit_err_q   <= credit_err_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
`ifdef PACKET_INJECTOR_THROTTLE_EN
      gap_q          <= gap_d;
`endif
    end
  end

  assign channel_out  = channel_out_q;
  assign packet_count = packet_count_q;
  assign credits      = credits_q;
  assign credit_err   = credit_err_q;

endmodule
`default_nettype wire

// File: tb/tb_packet_injector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_packet_injector                                                         |
// | Directed self-checking bench for packet_injector (default parameters).     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_packet_injector;

`ifdef PACKET_INJECTOR_THROTTLE_EN
  localparam int TB_GAP = 3;
`else
  localparam int TB_GAP = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [79:0] pkt_in;
  logic        pkt_valid;
  logic        pkt_ready;
  logic        credit_in;
  logic [15:0] channel_out;
  logic [31:0] packet_count;
  logic [1:0]  credits;
  logic        credit_err;

  int tests = 0;
  int fails = 0;

  packet_injector #(
    .CHANNEL_WIDTH(16), .FLITS(5), .CREDITS(2), .DEPTH(4), .GAP(TB_GAP)
  ) dut (
    .clk(clk), .reset(reset), .pkt_in(pkt_in), .pkt_valid(pkt_valid),
    .pkt_ready(pkt_ready), .credit_in(credit_in), .channel_out(channel_out),
    .packet_count(packet_count), .credits(credits), .credit_err(credit_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [79:0] mk(input logic [15:0] base);
    logic [79:0] p;
    for (int k = 0; k < 5; k++) p[k*16 +: 16] = base + 16'(k);
    return p;
  endfunction

  logic [15:0] stream [16];

  initial begin
    reset = 1'b1; pkt_in = '0; pkt_valid = 1'b0; credit_in = 1'b0;
    tick(); tick();
    chk("rst_chan", 32'(channel_out), 32'h0);
    chk("rst_pcnt", packet_count, 32'd0);
    chk("rst_cred", 32'(credits), 32'd2);
    chk("rst_err", 32'(credit_err), 32'd0);
    chk("rst_ready", 32'(pkt_ready), 32'd1);
    reset = 1'b0;

    // Single packet 0x1111..0x5555
    pkt_in = {16'h5555, 16'h4444, 16'h3333, 16'h2222, 16'h1111};
    pkt_valid = 1'b1;
    tick();
    pkt_valid = 1'b0;
    chk("p1_e0", 32'(channel_out), 32'h0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("p1_flit", 32'(channel_out), 32'h1111 * (k + 1));
      if (k == 0) chk("p1_cred", 32'(credits), 32'd1);
      if (k == 3) chk("p1_pcnt_pre", packet_count, 32'd0);
    end
    chk("p1_pcnt", packet_count, 32'd1);
    tick();
    chk("p1_idle", 32'(channel_out), 32'h0);
    credit_in = 1'b1;
    tick();
    credit_in = 1'b0;
    chk("p1_cred_back", 32'(credits), 32'd2);
    chk("p1_err", 32'(credit_err), 32'd0);
    tick(); tick(); tick();

    // Three packets, two credits: A and B contiguous (plus gap if throttled), C held
    for (int i = 0; i < 10 + TB_GAP; i++) begin
      if (i < 5)               stream[i] = 16'hA000 + 16'(i);
      else if (i < 5 + TB_GAP) stream[i] = 16'h0000;
      else                     stream[i] = 16'hB000 + 16'(i - 5 - TB_GAP);
    end
    pkt_in = mk(16'hA000); pkt_valid = 1'b1;
    tick();
    for (int i = 0; i < 10 + TB_GAP; i++) begin
      if (i == 0) pkt_in = mk(16'hB000);
      if (i == 1) pkt_in = mk(16'hC000);
      if (i == 2) pkt_valid = 1'b0;
      tick();
      chk("ab_stream", 32'(channel_out), 32'(stream[i]));
    end
    chk("ab_pcnt", packet_count, 32'd3);
    chk("ab_cred", 32'(credits), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("c_held", 32'(channel_out), 32'h0);
    end
    chk("c_ready", 32'(pkt_ready), 32'd1);
    credit_in = 1'b1;
    tick();
    credit_in = 1'b0;
    chk("c_t_chan", 32'(channel_out), 32'h0);
    chk("c_t_cred", 32'(credits), 32'd1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("c_flit", 32'(channel_out), 32'hC000 + k);
      if (k == 0) chk("c_cred", 32'(credits), 32'd0);
    end
    chk("c_pcnt", packet_count, 32'd4);

    // Fill FIFO with no credits; 5th packet must be refused
    for (int j = 0; j < 4; j++) begin
      pkt_in = mk(16'hD000 + 16'(j * 16'h100)); pkt_valid = 1'b1;
      tick();
      chk("fill_ready", 32'(pkt_ready), (j < 3) ? 32'd1 : 32'd0);
    end
    pkt_in = mk(16'hEEE0);
    tick();
    pkt_valid = 1'b0;
    chk("full_ready", 32'(pkt_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("full_idle", 32'(channel_out), 32'h0);
    end
    for (int j = 0; j < 4; j++) begin
      credit_in = 1'b1;
      tick();
      credit_in = 1'b0;
      tick();
      chk("drain_f0", 32'(channel_out), 32'hD000 + j * 32'h100);
      if (j == 0) chk("drain_ready", 32'(pkt_ready), 32'd1);
      tick(); tick(); tick();
      tick();
      chk("drain_f4", 32'(channel_out), 32'hD004 + j * 32'h100);
      for (int i = 0; i < 4; i++) tick();
    end
    credit_in = 1'b1;
    tick();
    credit_in = 1'b0;
    tick();
    chk("drain_empty", 32'(channel_out), 32'h0);
    chk("drain_pcnt", packet_count, 32'd8);
    credit_in = 1'b1;
    tick();
    credit_in = 1'b0;
    tick();
    chk("cred_full", 32'(credits), 32'd2);
    chk("cred_err0", 32'(credit_err), 32'd0);

    // Credit return in the same cycle as a launch: net unchanged
    pkt_in = mk(16'hE000); pkt_valid = 1'b1;
    tick();
    pkt_valid = 1'b0; credit_in = 1'b1;
    tick();
    credit_in = 1'b0;
    chk("sim_f0", 32'(channel_out), 32'hE000);
    chk("sim_cred", 32'(credits), 32'd2);
    chk("sim_err", 32'(credit_err), 32'd0);
    for (int i = 0; i < 8; i++) tick();
    chk("sim_pcnt", packet_count, 32'd9);
    // Over-return: saturate and set sticky error
    credit_in = 1'b1;
    tick();
    credit_in = 1'b0;
    chk("ovr_cred", 32'(credits), 32'd2);
    chk("ovr_err", 32'(credit_err), 32'd1);
    tick(); tick();
    chk("ovr_sticky", 32'(credit_err), 32'd1);

    // Reset after flit 2 with a second packet queued
    pkt_in = mk(16'hF000); pkt_valid = 1'b1;
    tick();
    pkt_in = mk(16'h9000);
    tick();
    pkt_valid = 1'b0;
    tick(); tick();
    chk("mid_f2", 32'(channel_out), 32'hF002);
    reset = 1'b1;
    tick();
    chk("mid_chan", 32'(channel_out), 32'h0);
    chk("mid_cred", 32'(credits), 32'd2);
    chk("mid_pcnt", packet_count, 32'd0);
    chk("mid_ready", 32'(pkt_ready), 32'd1);
    chk("mid_err", 32'(credit_err), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("mid_quiet", 32'(channel_out), 32'h0);
    end
    chk("mid_pcnt_end", packet_count, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/packet_injector.md
# packet_injector

Synthesizable, parametrised NoC packet source that replaces the behavioural test source at router input ports. Accepts whole packets from a producer (PE model, traffic generator or bench) into a small packet FIFO, serialises each packet into FLITS flits on one channel, and obeys the router's credit-based flow control. It adds packet buffering, configurable packet length and credit depth, and an optional injection-rate throttle.

## Interface
- CHANNEL_WIDTH, 16: flit width in bits; matches the system channel width.
- FLITS, 5: flits per packet; legal range 2..16.
- CREDITS, 2: initial and maximum credits (downstream buffer slots, in packets).
- DEPTH, 4: packet FIFO depth in packets; power of two, ≥2.
- GAP, 0: idle cycles inserted after each packet; used only when the throttle is compiled in.
- clk  in  1  system clock, all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- pkt_in  in  FLITS*CHANNEL_WIDTH  packet; flit 0 (header) in bits [CHANNEL_WIDTH-1:0], flit k in the next slice up.
- pkt_valid  in  1  pkt_in valid.
- pkt_ready  out  1  FIFO can accept; transfer on pkt_valid && pkt_ready.
- credit_in  in  1  one-cycle pulse, returns one credit.
- channel_out  out  CHANNEL_WIDTH  registered flit output; all zeros when idle.
- packet_count  out  32  packets fully launched since reset; wraps.
- credits  out  $clog2(CREDITS+1)  current credit count.
- credit_err  out  1  sticky: credit returned while count == CREDITS.

## Operation
- Reset values: channel_out 0, packet_count 0, credits CREDITS, credit_err 0, FIFO empty, pkt_ready 1, FSM IDLE.
- FIFO: pkt_ready = !full; no write-through bypass. Write and read in the same cycle are allowed. A write is accepted only when ready is high; a full FIFO drops nothing.
- FSM states: IDLE, SEND, GAP.
  - IDLE: if FIFO non-empty and credits > 0, pop the head packet into the shift register, drive flit 0, consume one credit, flit index = 1, and go to SEND. Otherwise drive zeros.
  - SEND: drive flit[index] and increment the index. On the last flit (index == FLITS-1), increment packet_count.
    - Then, if GAP > 0 and the throttle is built in, go to GAP.
    - Else, if FIFO non-empty and credits > 0, launch the next flit 0 on the following cycle (back-to-back, no bubble).
    - Else go to IDLE.
  - GAP: drive zeros for GAP cycles (down-counter), then go to IDLE.
- Credits: decrement on flit-0 launch; increment on credit_in.
  - Simultaneous launch and credit_in: net unchanged.
  - credit_in at count == CREDITS with no same-cycle launch: count saturates and credit_err is set until reset.
- Credits are checked only at packet boundaries. A packet in progress always completes, even if credits reach 0.
- Reset mid-packet: the remaining flits are discarded, channel_out is zero from the next cycle, the FIFO is flushed, and credits return to CREDITS.

## Timing
- Packet accepted at edge E into an empty, idle injector with credits > 0: flit 0 is on channel_out after edge E+1, and flit k after edge E+1+k.
- One packet occupies exactly FLITS consecutive cycles.
- Back-to-back throughput: one flit per cycle with no idle cycle between packets (GAP = 0 or throttle absent).
- credit_in sampled at edge T affects the launch decision at edge T+1. A credit arriving while blocked in IDLE gives flit 0 after edge T+1.
- packet_count updates at the same edge that the last flit appears.
- pkt_ready falls in the cycle after the write that fills the FIFO, and rises in the cycle after the pop that frees a slot.

## Configuration
- PACKET_INJECTOR_THROTTLE_EN defined:
  - GAP state and down-counter are built.
  - Each packet is followed by GAP zero cycles before the next flit 0 can launch, even with credits and queued packets.
- Not defined:
  - No GAP state or counter; the GAP parameter is ignored.
  - Packets go out back-to-back whenever credits and data allow.

## Test plan
- Reset, one packet (flits 0x1111..0x5555), CREDITS=2 -> flits appear in order after edges E+1..E+5; packet_count=1; credits=1; channel_out=0 afterwards.
- Three packets queued, CREDITS=2, no credit_in -> two packets back-to-back (10 contiguous flits), third held in FIFO; a credit_in pulse at edge T -> third flit 0 after T+1; packet_count=3.
- Fill FIFO with DEPTH=4 while credits=0 -> pkt_ready low after the 4th write; 5th pkt_valid is not accepted; FIFO contents are unchanged when drained.
- Simultaneous credit_in and flit-0 launch -> credits unchanged. credit_in at credits=CREDITS -> credits stays 2 and credit_err=1 until reset.
- Reset asserted after flit 2 of a packet -> channel_out=0 next cycle, credits=CREDITS, packet_count=0, pkt_ready=1, no residual flits.
- With PACKET_INJECTOR_THROTTLE_EN and GAP=3, two queued packets -> exactly 3 zero cycles between flit 4 of packet 1 and flit 0 of packet 2.
